bar_renderer: RTL and testbench

BAR_RENDERER -- requirements
Module: bar_renderer

---
 rtl/bar_renderer.sv | 207 ++++++++++++++++++++
 tb/tb_bar_renderer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bar_renderer.sv
// ============================================================================
// bar_renderer
// ----------------------------------------------------------------------------
// Draws a row of vertical bars, like a spectrum analyser, over a shaded
// background. Bar heights are double-buffered. Writes go to shadow heights.
// The active heights used for drawing take the shadow values only on
// frame_start, so a bar never changes height partway down the screen.
//
// Optional feature (macro PEAK_HOLD_EN):
//   Each bar keeps a peak marker. On frame_start the marker takes the larger
//   of the new height and the old peak less PEAK_DECAY. A white row is drawn
//   at the peak height. When the macro is not defined, no peak registers
//   exist and colouring uses only bar or background.
//
// Parameters:
//   NUM_BARS    number of bars (1..16)
//   BAR_W       bar width in pixels
//   BAR_GAP     gap between adjacent bars in pixels
//   X_ORIGIN    left x of bar 0
//   BASE_Y      bottom row shared by all bars
//   PEAK_DECAY  distance the peak marker falls each frame, in pixels
//
// Ports:
//   Clk          system clock
//   Reset        synchronous, active-high reset
//   frame_start  one-cycle pulse at the start of vertical blank
//   wr_en        height-write strobe
//   wr_idx       bar index for the write (an out-of-range index is ignored)
//   wr_height    new bar height in pixels (clamped to BASE_Y+1)
//   DrawX/DrawY  current pixel coordinate
//   Red/Green/Blue  registered pixel colour, 2 cycles after DrawX/DrawY
// ============================================================================
module bar_renderer #(
    parameter int unsigned NUM_BARS   = 10,
    parameter int unsigned BAR_W      = 53,
    parameter int unsigned BAR_GAP    = 10,
    parameter int unsigned X_ORIGIN   = 10,
    parameter int unsigned BASE_Y     = 479,
    parameter int unsigned PEAK_DECAY = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_start,
    input  logic       wr_en,
    input  logic [3:0] wr_idx,
    input  logic [9:0] wr_height,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [7:0] Red,
    output logic [7:0] Green,
    output logic [7:0] Blue
);

    // All position arithmetic is done in 11 bits, so sums cannot wrap.
    localparam logic [10:0] BASE_Y11 = 11'(BASE_Y);
    localparam logic [10:0] MAX_H11  = 11'(BASE_Y + 1);

    localparam logic [23:0] RGB_PEAK = 24'hFFFFFF;
    localparam logic [23:0] RGB_BAR  = 24'hFF5500;

    logic [9:0]  shadow [NUM_BARS];
    logic [9:0]  active [NUM_BARS];

    logic [10:0] x11;
    logic [10:0] y11;
    logic [9:0]  wr_clamped;
    logic        wr_ok;

    logic [NUM_BARS-1:0] in_span;
    logic [NUM_BARS-1:0] bar_hit_v;
    logic                bar_hit_c;
    logic                peak_hit_c;

    logic                s1_bar;
    logic                s1_peak;
    logic [6:0]          s1_xhi;

    assign x11 = {1'b0, DrawX};
    assign y11 = {1'b0, DrawY};

    // ------------------------------------------------------------------
    // Height write path
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal set in always_comb gets a default first, so no
        // path can leave it unassigned and infer a latch.
        wr_clamped = wr_height;
        if ({1'b0, wr_height} > MAX_H11)
            wr_clamped = MAX_H11[9:0];
    end

    assign wr_ok = wr_en && ({28'd0, wr_idx} < NUM_BARS);

    // Double-buffered heights. Because the updates are non-blocking, a
    // frame_start in the same cycle as a write copies the shadow value from
    // before the write. The new height is then shown from the next frame.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            // NOTE: this register file is small and must read as zero right
            // after reset, so every entry is cleared explicitly. Large RAMs
            // would normally be left unreset.
            for (int i = 0; i < NUM_BARS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments only. This
            // is what gives the pre-write snapshot described above.
            if (frame_start) begin
                for (int i = 0; i < NUM_BARS; i++)
                    active[i] <= shadow[i];
            end
            if (wr_ok)
                shadow[wr_idx] <= wr_clamped;
        end
    end

`ifdef PEAK_HOLD_EN
    // ------------------------------------------------------------------
    // Peak-hold markers
    // ------------------------------------------------------------------
    localparam logic [9:0] DECAY10 = 10'(PEAK_DECAY);

    logic [9:0]          peak [NUM_BARS];
    logic [NUM_BARS-1:0] peak_hit_v;

    function automatic logic [9:0] next_peak(input logic [9:0] new_h,
                                             input logic [9:0] old_p);
        logic [9:0] decayed;
        decayed = (old_p > DECAY10) ? (old_p - DECAY10) : 10'd0;
        return (new_h > decayed) ? new_h : decayed;
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_BARS; i++)
                peak[i] <= '0;
        end else if (frame_start) begin
            // The new active height is the shadow value copied on this edge.
            for (int i = 0; i < NUM_BARS; i++)
                peak[i] <= next_peak(shadow[i], peak[i]);
        end
    end

    assign peak_hit_c = |peak_hit_v;
`else
    assign peak_hit_c = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Per-bar hit tests
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_BARS; g++) begin : g_bar
        localparam int unsigned  XS_I = X_ORIGIN + g * (BAR_W + BAR_GAP);
        localparam logic [10:0]  XS   = 11'(XS_I);
        localparam logic [10:0]  XE   = 11'(XS_I + BAR_W - 1);

        assign in_span[g] = (x11 >= XS) && (x11 <= XE);

        // The condition DrawY > BASE_Y - h is rewritten as DrawY + h > BASE_Y.
        // This keeps the arithmetic from going below zero when h = BASE_Y+1.
        assign bar_hit_v[g] = in_span[g]
                           && (active[g] != '0)
                           && ((y11 + {1'b0, active[g]}) > BASE_Y11)
                           && (y11 <= BASE_Y11);

`ifdef PEAK_HOLD_EN
        // The marker row is DrawY == BASE_Y - peak + 1, written as a sum.
        assign peak_hit_v[g] = in_span[g]
                            && (peak[g] != '0)
                            && ((y11 + {1'b0, peak[g]}) == MAX_H11);
`endif
    end

    assign bar_hit_c = |bar_hit_v;

    // ------------------------------------------------------------------
    // Two-stage output pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_bar  <= 1'b0;
            s1_peak <= 1'b0;
            s1_xhi  <= '0;
            Red     <= '0;
            Green   <= '0;
            Blue    <= '0;
        end else begin
            s1_bar  <= bar_hit_c;
            s1_peak <= peak_hit_c;
            s1_xhi  <= DrawX[9:3];

            if (s1_peak) begin
                {Red, Green, Blue} <= RGB_PEAK;
            end else if (s1_bar) begin
                {Red, Green, Blue} <= RGB_BAR;
            end else begin
                // Background: blue shades darker from left to right in
                // 8-pixel columns.
                Red   <= 8'h00;
                Green <= 8'h00;
                Blue  <= 8'h7F - {1'b0, s1_xhi};
            end
        end
    end

endmodule

// File: tb/tb_bar_renderer.sv
// ============================================================================
// tb_bar_renderer
// ----------------------------------------------------------------------------
// Scoreboard bench for bar_renderer with default parameters. A pixel request
// pushes its hand-computed expected colour into a queue. A monitor compares
// the DUT output whenever a tracked request has passed through the 2-cycle
// pipeline. Reset behaviour is checked directly against constants.
// ============================================================================
module tb_bar_renderer;

    logic       Clk;
    logic       Reset;
    logic       frame_start;
    logic       wr_en;
    logic [3:0] wr_idx;
    logic [9:0] wr_height;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [7:0] Red;
    logic [7:0] Green;
    logic [7:0] Blue;

    typedef struct {
        logic [23:0] rgb;
        string       name;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    logic valid_in = 1'b0;
    logic v1 = 1'b0;
    logic v2 = 1'b0;

    localparam logic [23:0] BAR   = 24'hFF5500;
    localparam logic [23:0] WHITE = 24'hFFFFFF;

    bar_renderer dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .wr_height   (wr_height),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .Red         (Red),
        .Green       (Green),
        .Blue        (Blue)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Marks which output cycles belong to tracked pixel requests.
    always @(posedge Clk) begin
        v1 <= valid_in;
        v2 <= v1;
    end

    task automatic check(input string name, input logic [23:0] got,
                         input logic [23:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %06h expected %06h", name, got, exp);
        end
    endtask

    // Monitor: pops one expectation per tracked output.
    always @(negedge Clk) begin
        if (v2) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL monitor: output with empty scoreboard");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check(e.name, {Red, Green, Blue}, e.rgb);
            end
        end
    end

    // ---------------------------------------------------------------
    // Stimulus tasks. Each task takes one clock cycle.
    // ---------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge Clk);
            valid_in = 1'b0; wr_en = 1'b0; frame_start = 1'b0;
        end
    endtask

    task automatic wr(input int idx, input int h);
        @(negedge Clk);
        valid_in = 1'b0; frame_start = 1'b0;
        wr_en = 1'b1; wr_idx = 4'(idx); wr_height = 10'(h);
    endtask

    task automatic frame();
        @(negedge Clk);
        valid_in = 1'b0; wr_en = 1'b0; frame_start = 1'b1;
    endtask

    task automatic wr_frame(input int idx, input int h);
        @(negedge Clk);
        valid_in = 1'b0; frame_start = 1'b1;
        wr_en = 1'b1; wr_idx = 4'(idx); wr_height = 10'(h);
    endtask

    task automatic pix(input int x, input int y, input logic [23:0] exp,
                       input string name);
        exp_t e;
        @(negedge Clk);
        wr_en = 1'b0; frame_start = 1'b0;
        DrawX = 10'(x); DrawY = 10'(y); valid_in = 1'b1;
        e.rgb = exp; e.name = name;
        sb.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; frame_start = 1'b0; wr_en = 1'b0;
        wr_idx = '0; wr_height = '0; DrawX = '0; DrawY = '0;
        repeat (3) @(negedge Clk);
        check("reset_state", {Red, Green, Blue}, 24'h000000);
        Reset = 1'b0;
        @(negedge Clk);
        check("post_reset_0", {Red, Green, Blue}, 24'h00007F);
        @(negedge Clk);
        check("post_reset_1", {Red, Green, Blue}, 24'h00007F);

        // Deferred update: the write shows only after frame_start.
        wr(0, 50);
        pix(10, 479, 24'h00007E, "deferred_before");
        frame();
        pix(10, 479, BAR,         "deferred_after");
        pix(10, 430, BAR,         "bar0_top");
        pix(10, 429, 24'h00007E,  "bar0_above");
        pix(62, 479, BAR,         "bar0_last_col");
        pix(63, 479, 24'h000078,  "bar0_gap");

        // Write then frame: bar 2 = 100.
        wr(2, 100);
        frame();
        for (int y = 380; y <= 479; y++)
            pix(150, y, BAR, "bar2_col");
        pix(150, 379, 24'h00006D, "bar2_above");
        pix(150, 500, 24'h00006D, "bar2_below_base");
        pix(136, 479, BAR,        "bar2_first_col");
        pix(135, 479, 24'h00006F, "bar2_left_gap");
        pix(188, 479, BAR,        "bar2_last_col");
        pix(189, 479, 24'h000068, "bar2_right_gap");
        pix(630, 479, 24'h000031, "past_last_bar");
        pix(5,   479, 24'h00007F, "left_margin");

        // Simultaneous write and frame_start.
        wr(1, 20);
        frame();
        wr_frame(1, 200);
        pix(80, 460, BAR,        "simul_this_frame");
        pix(80, 459, 24'h000075, "simul_this_frame_above");
        frame();
        pix(80, 280, BAR,        "simul_next_frame");
        pix(80, 279, 24'h000075, "simul_next_frame_above");

        // Clamp, then a write to an out-of-range index.
        wr(3, 1023);
        frame();
        for (int y = 0; y <= 479; y++)
            pix(200, y, BAR, "clamp_col");
        wr(12, 5);
        frame();
        pix(200, 0,   BAR,        "ignore_bar3");
        pix(150, 380, BAR,        "ignore_bar2_top");
        pix(150, 379, 24'h00006D, "ignore_bar2_above");
        pix(10,  430, BAR,        "ignore_bar0_top");
        pix(10,  429, 24'h00007E, "ignore_bar0_above");
        pix(262, 479, 24'h00005F, "ignore_bar4");

        // Peak decay on bar 4.
        wr(4, 100);
        frame();
`ifdef PEAK_HOLD_EN
        pix(262, 380, WHITE,      "peak_f1");
`else
        pix(262, 380, BAR,        "nopeak_f1");
`endif
        pix(262, 479, BAR,        "peak_f1_body");
        wr(4, 0);
        frame();
`ifdef PEAK_HOLD_EN
        pix(262, 382, WHITE,      "peak_f2");
`else
        pix(262, 382, 24'h00005F, "nopeak_f2");
`endif
        pix(262, 380, 24'h00005F, "peak_f2_old_row");
        pix(262, 479, 24'h00005F, "peak_f2_body");
        frame();
`ifdef PEAK_HOLD_EN
        pix(262, 384, WHITE,      "peak_f3");
`else
        pix(262, 384, 24'h00005F, "nopeak_f3");
`endif
        pix(262, 382, 24'h00005F, "peak_f3_old_row");

        // Reset in the middle of a frame while bars are lit. Reset takes
        // priority over a write and frame_start in the same cycle.
        pix(150, 479, BAR, "pre_reset_pix");
        idle(3);
        check("pre_reset_hold", {Red, Green, Blue}, BAR);
        @(negedge Clk);
        Reset = 1'b1; frame_start = 1'b1; wr_en = 1'b1;
        wr_idx = 4'd5; wr_height = 10'd300;
        @(negedge Clk);
        check("reset_mid", {Red, Green, Blue}, 24'h000000);
        Reset = 1'b0; frame_start = 1'b0; wr_en = 1'b0;
        DrawX = 10'd0; DrawY = 10'd479;

        // Latency: alternating DrawX must appear exactly 2 cycles later.
        pix(150, 479, 24'h00006D, "lat_a");
        pix(0,   479, 24'h00007F, "lat_b");
        pix(150, 479, 24'h00006D, "lat_c");
        pix(0,   479, 24'h00007F, "lat_d");
        pix(150, 479, 24'h00006D, "lat_e");
        frame();
        pix(150, 479, 24'h00006D, "reset_cleared_bar2");
        pix(330, 479, 24'h000056, "reset_ignored_wr5");
        pix(10,  479, 24'h00007E, "reset_cleared_bar0");

        idle(4);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d outputs outstanding, expected 0",
                     sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
